// File: rtl/rand_arb_pkg.sv
// ----------------------------------------------------------------------------
// rand_arb_pkg
// Shared definitions for the random-number arbiter:
//   - state_e        : FSM state encoding (IDLE / DRAW)
//   - MAX_TRIES_DEF  : default rejection-sampling attempt budget
//   - DATA_W         : width of the random byte and per-requester limit
//   - limit_to_mask  : smallest 2^k-1 covering limit-1 (limit 0 means 256)
//   - sample_ok      : sample < limit test with limit 0 treated as 256
// ----------------------------------------------------------------------------
package rand_arb_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned MAX_TRIES_DEF = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_e;

  // limit-1 wraps to 0xFF for limit 0, so "0 means 256" falls out naturally;
  // smearing the top set bit downward yields the covering 2^k-1 mask.
  function automatic logic [DATA_W-1:0] limit_to_mask(input logic [DATA_W-1:0] lim);
    logic [DATA_W-1:0] m;
    m = lim - DATA_W'(1);
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  function automatic logic sample_ok(input logic [DATA_W-1:0] sample,
                                     input logic [DATA_W-1:0] lim);
    return (lim == '0) || (sample < lim);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector. Searches from (last_gnt+1) mod
// NREQ upward, wrapping to 0.
// Ports:
//   req      in  [NREQ-1:0]  request levels
//   last_gnt in  [IDXW-1:0]  index of the most recent grant
//   winner   out [IDXW-1:0]  selected requester (valid when any_req)
//   any_req  out             at least one request is high
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_gnt,
  output logic [IDXW-1:0] winner,
  output logic            any_req
);

  logic            hi_found;
  logic            lo_found;
  logic [IDXW-1:0] hi_idx;
  logic [IDXW-1:0] lo_idx;

  // hi_*: first requester above last_gnt; lo_*: first requester overall
  // (the wrap-around candidate when nothing above last_gnt is requesting).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (req[j]) begin
        if (!hi_found && (IDXW'(j) > last_gnt)) begin
          hi_found = 1'b1;
          hi_idx   = IDXW'(j);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDXW'(j);
        end
      end
    end
    winner  = hi_found ? hi_idx : lo_idx;
    any_req = |req;
  end

endmodule

// File: rtl/rand_arbiter.sv
// ----------------------------------------------------------------------------
// rand_arbiter
// Shares one random byte source among NREQ requesters. A round-robin winner
// is chosen in IDLE; in DRAW each cycle's rnd_in is masked and accepted if
// below the winner's latched limit (rejection sampling). After MAX_TRIES
// consecutive rejects the sample is forced in range with mask>>1.
// Ports:
//   clk        in                 system clock, rising edge
//   reset_n    in                 synchronous active-low reset
//   rnd_in     in  [7:0]          fresh random byte every cycle
//   req        in  [NREQ-1:0]     request levels, held until granted
//   limit      in  [8*NREQ-1:0]   per-requester exclusive bound, 0 = 256
//   gnt        out [NREQ-1:0]     one-hot single-cycle grant
//   rnd_out    out [7:0]          granted value, held until next grant
//   rnd_valid  out                single-cycle pulse with gnt
// ----------------------------------------------------------------------------
module rand_arbiter
  import rand_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        rnd_in,
  input  logic [NREQ-1:0]          req,
  input  logic [DATA_W*NREQ-1:0]   limit,
  output logic [NREQ-1:0]          gnt,
  output logic [DATA_W-1:0]        rnd_out,
  output logic                     rnd_valid
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TRYW = $clog2(MAX_TRIES + 1);
  localparam logic [TRYW-1:0] LAST_TRY = TRYW'(MAX_TRIES - 1);

  state_e              state_q,   state_d;
  logic [IDXW-1:0]     win_q,     win_d;
  logic [IDXW-1:0]     last_q,    last_d;
  logic [DATA_W-1:0]   lim_q,     lim_d;
  logic [DATA_W-1:0]   mask_q,    mask_d;
  logic [TRYW-1:0]     try_q,     try_d;
  logic [NREQ-1:0]     gnt_q,     gnt_d;
  logic [DATA_W-1:0]   rnd_out_q, rnd_out_d;
  logic                valid_q,   valid_d;

  logic [IDXW-1:0]     pick_idx;
  logic                any_req;
  logic [DATA_W-1:0]   lim_arr [NREQ];
  logic [DATA_W-1:0]   sample;
  logic                accept;

  // Unflatten the per-requester limits.
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_lim
    assign lim_arr[g] = limit[DATA_W*g +: DATA_W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_q),
    .winner   (pick_idx),
    .any_req  (any_req)
  );

  assign sample = rnd_in & mask_q;
  assign accept = sample_ok(sample, lim_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    lim_d     = lim_q;
    mask_d    = mask_q;
    try_d     = try_q;
    gnt_d     = '0;
    valid_d   = 1'b0;
    rnd_out_d = rnd_out_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          win_d   = pick_idx;
          lim_d   = lim_arr[pick_idx];
          mask_d  = limit_to_mask(lim_arr[pick_idx]);
          try_d   = '0;
          state_d = ST_DRAW;
        end
      end

      ST_DRAW: begin
        if (!req[win_q]) begin
          // Requester withdrew: abandon without touching last_gnt/rnd_out.
          state_d = ST_IDLE;
        end else if (accept || (try_q == LAST_TRY)) begin
          // On the final reject, mask>>1 is below limit by construction.
          rnd_out_d = accept ? sample : (sample & (mask_q >> 1));
          gnt_d     = NREQ'(1) << win_q;
          valid_d   = 1'b1;
          last_d    = win_q;
          state_d   = ST_IDLE;
        end else begin
          try_d = try_q + TRYW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      last_q    <= IDXW'(NREQ - 1);
      lim_q     <= '0;
      mask_q    <= '0;
      try_q     <= '0;
      gnt_q     <= '0;
      rnd_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      lim_q     <= lim_d;
      mask_q    <= mask_d;
      try_q     <= try_d;
      gnt_q     <= gnt_d;
      rnd_out_q <= rnd_out_d;
      valid_q   <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_out   = rnd_out_q;
  assign rnd_valid = valid_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rand_arbiter
// Directed, self-checking bench for rand_arbiter (NREQ=4, MAX_TRIES=16).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ----------------------------------------------------------------------------
module tb_rand_arbiter;

  localparam int unsigned NREQ = 4;

  logic              clk;
  logic              reset_n;
  logic [7:0]        rnd_in;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] limit;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        rnd_out;
  logic              rnd_valid;

  int checks = 0;
  int errors = 0;

  rand_arbiter #(
    .NREQ      (NREQ),
    .MAX_TRIES (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rnd_in    (rnd_in),
    .req       (req),
    .limit     (limit),
    .gnt       (gnt),
    .rnd_out   (rnd_out),
    .rnd_valid (rnd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [NREQ-1:0] eg, input logic [7:0] eo);
    check({tag, ".gnt"},   32'(gnt),       32'(eg));
    check({tag, ".valid"}, 32'(rnd_valid), 32'(1));
    check({tag, ".out"},   32'(rnd_out),   32'(eo));
  endtask

  task automatic check_idle(input string tag, input logic [7:0] eo);
    check({tag, ".gnt"},   32'(gnt),       32'(0));
    check({tag, ".valid"}, 32'(rnd_valid), 32'(0));
    check({tag, ".out"},   32'(rnd_out),   32'(eo));
  endtask

  logic [7:0] rv;
  logic [7:0] rv_q;
  int         quiet;

  initial begin
    reset_n = 1'b0;
    rnd_in  = 8'h00;
    req     = '0;
    limit   = '0;
    step(3);
    check_idle("reset", 8'h00);
    reset_n = 1'b1;
    step(1);

    // Basic accept: limit 6 -> mask 7, 3 accepted on the first draw.
    req = 4'b0001; limit[7:0] = 8'd6; rnd_in = 8'h03;
    step(1);
    check("basic.draw_gnt", 32'(gnt), 32'(0));
    step(1);
    check_grant("basic", 4'b0001, 8'h03);
    req = '0;
    step(1);
    check_idle("basic.after", 8'h03);

    // Two rejects (7, 6 after masking) then accept 2.
    req = 4'b0001; limit[7:0] = 8'd6; rnd_in = 8'h00;
    step(1);
    rnd_in = 8'h07;
    step(1);
    check("rej.1", 32'(gnt), 32'(0));
    rnd_in = 8'h0E;
    step(1);
    check("rej.2", 32'(gnt), 32'(0));
    rnd_in = 8'h02;
    step(1);
    check_grant("rej", 4'b0001, 8'h02);
    req = '0;
    step(1);

    // Sixteen rejects then fallback 0x07 & 0x03 = 3.
    req = 4'b0001; limit[7:0] = 8'd5; rnd_in = 8'h07;
    quiet = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (gnt != '0 || rnd_valid) quiet++;
    end
    check("fallback.early_grants", 32'(quiet), 32'(0));
    step(1);
    check_grant("fallback", 4'b0001, 8'h03);
    req = '0;
    step(1);

    // Limit change of the winner during DRAW is ignored (latched 6, not 2).
    req = 4'b0001; limit[7:0] = 8'd6; rnd_in = 8'h00;
    step(1);
    limit[7:0] = 8'd2; rnd_in = 8'h05;
    step(1);
    check_grant("latch_lim", 4'b0001, 8'h05);
    req = '0;
    step(1);

    // Reset, then all four requesting with limit 0: order 0,1,2,3,0.
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    limit = '0; req = 4'b1111;
    rv_q = 8'h00;
    for (int i = 0; i < 10; i++) begin
      rv = 8'(8'h21 + 8'(i) * 8'h13);
      rnd_in = rv;
      step(1);
      if ((i % 2) == 1) begin
        check_grant($sformatf("rr.%0d", i / 2), NREQ'(1) << ((i / 2) % 4), rv);
        rv_q = rv;
      end else begin
        check_idle($sformatf("rr.gap%0d", i / 2), rv_q);
      end
    end
    req = '0;
    step(1);

    // limit 1 -> always 0; limit 0 with 0xFF -> 0xFF.
    req = 4'b0100; limit[23:16] = 8'd1; rnd_in = 8'hFF;
    step(2);
    check_grant("lim1", 4'b0100, 8'h00);
    req = '0;
    step(1);
    req = 4'b0100; limit[23:16] = 8'd0; rnd_in = 8'hFF;
    step(2);
    check_grant("lim256", 4'b0100, 8'hFF);
    req = '0;
    step(1);

    // Abort: req0 drops while rejecting; last_gnt must stay at 2.
    req = 4'b0001; limit[7:0] = 8'd5; rnd_in = 8'h07;
    step(2);
    check("abort.rejecting", 32'(gnt), 32'(0));
    req = '0;
    step(1);
    check_idle("abort", 8'hFF);
    // From last_gnt=2 the search starts at 3, so requester 0 beats 1.
    req = 4'b0011; limit[15:0] = 16'h0000; rnd_in = 8'h5A;
    step(1);
    check("abort.redraw_gap", 32'(gnt), 32'(0));
    step(1);
    check_grant("abort.next", 4'b0001, 8'h5A);
    req = '0;
    step(1);

    // Reset asserted in DRAW abandons the draw.
    req = 4'b0001; limit[7:0] = 8'd5; rnd_in = 8'h07;
    step(2);
    check("rstdraw.rejecting", 32'(gnt), 32'(0));
    reset_n = 1'b0;
    step(1);
    check_idle("rstdraw", 8'h00);
    reset_n = 1'b1; rnd_in = 8'h03;
    step(1);
    check("rstdraw.idle_gap", 32'(gnt), 32'(0));
    step(1);
    check_grant("rstdraw.next", 4'b0001, 8'h03);
    req = '0;
    step(1);
    check_idle("end", 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
